// File: rtl/mac_feed_sequencer.sv
// Feeds one MAC-array pass: weight lines onto the weight port, then IFM beats
// with inter/accum segment flags and lane mask, each side behind one output register.
module mac_feed_sequencer #(
  parameter int ELEM_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [CNT_W-1:0]        cfg_wfm_lines,
  input  logic [CNT_W-1:0]        cfg_inter_len,
  input  logic [CNT_W-1:0]        cfg_accum_len,
  input  logic [CNT_W-1:0]        cfg_group_num,
  input  logic [63:0]             cfg_lane_mask,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  input  logic                    wfm_in_valid,
  output logic                    wfm_in_ready,
  input  logic [64*ELEM_W-1:0]    wfm_in_data,
  input  logic                    ifm_in_valid,
  output logic                    ifm_in_ready,
  input  logic [64*ELEM_W-1:0]    ifm_in_data,
  output logic                    mac_wfm_valid,
  input  logic                    mac_wfm_ready,
  output logic [64*ELEM_W:0]      mac_wfm,
  output logic                    mac_ifm_valid,
  input  logic                    mac_ifm_ready,
  output logic [64*ELEM_W+65:0]   mac_ifm
);

  typedef enum logic [2:0] {IDLE, LOAD_W, W_DRAIN, STREAM, S_DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lines_q, inter_q, accum_q, group_q;
  logic [63:0]      mask_q;
  logic [CNT_W-1:0] wl_cnt, beat, seg, grp;
  logic             cfg_zero, wfm_xfer, ifm_xfer;
  logic             is_last_line, inter_end, accum_end, last_beat;

  assign cfg_zero = (cfg_wfm_lines == '0) || (cfg_inter_len == '0) ||
                    (cfg_accum_len == '0) || (cfg_group_num == '0);

  assign is_last_line = (wl_cnt == lines_q - CNT_W'(1));
  assign inter_end    = (beat == inter_q - CNT_W'(1));
  assign accum_end    = inter_end && (seg == accum_q - CNT_W'(1));
  assign last_beat    = accum_end && (grp == group_q - CNT_W'(1));

  assign wfm_xfer = wfm_in_valid && wfm_in_ready;
  assign ifm_xfer = ifm_in_valid && ifm_in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    wfm_in_ready = 1'b0;
    ifm_in_ready = 1'b0;
    case (state)
      IDLE:    if (cfg_start && !cfg_zero) state_nxt = LOAD_W;
      LOAD_W: begin
        wfm_in_ready = !mac_wfm_valid || mac_wfm_ready;
        if (wfm_in_valid && wfm_in_ready && is_last_line) state_nxt = W_DRAIN;
      end
      // Leave as soon as the last weight line is taken so IFM can start next cycle.
      W_DRAIN: if (!mac_wfm_valid || mac_wfm_ready) state_nxt = STREAM;
      STREAM: begin
        ifm_in_ready = !mac_ifm_valid || mac_ifm_ready;
        if (ifm_in_valid && ifm_in_ready && last_beat) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (!mac_ifm_valid || mac_ifm_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      lines_q <= '0;
      inter_q <= '0;
      accum_q <= '0;
      group_q <= '0;
      mask_q  <= '0;
      wl_cnt  <= '0;
      beat    <= '0;
      seg     <= '0;
      grp     <= '0;
    end else begin
      done    <= (state == S_DRAIN) && (!mac_ifm_valid || mac_ifm_ready);
      cfg_err <= (state == IDLE) && cfg_start && cfg_zero;
      if (state == IDLE && cfg_start && !cfg_zero) begin
        lines_q <= cfg_wfm_lines;
        inter_q <= cfg_inter_len;
        accum_q <= cfg_accum_len;
        group_q <= cfg_group_num;
        mask_q  <= cfg_lane_mask;
        wl_cnt  <= '0;
        beat    <= '0;
        seg     <= '0;
        grp     <= '0;
      end
      if (wfm_xfer) wl_cnt <= wl_cnt + CNT_W'(1);
      if (ifm_xfer) begin
        if (inter_end) begin
          beat <= '0;
          if (accum_end) begin
            seg <= '0;
            grp <= grp + CNT_W'(1);
          end else begin
            seg <= seg + CNT_W'(1);
          end
        end else begin
          beat <= beat + CNT_W'(1);
        end
      end
    end
  end

  // A refill in the same cycle as a MAC drain keeps valid high with the new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_wfm_valid <= 1'b0;
      mac_wfm       <= '0;
      mac_ifm_valid <= 1'b0;
      mac_ifm       <= '0;
    end else begin
      if (wfm_xfer) begin
        mac_wfm_valid <= 1'b1;
        mac_wfm       <= {wfm_in_data, is_last_line};
      end else if (mac_wfm_ready) begin
        mac_wfm_valid <= 1'b0;
      end
      if (ifm_xfer) begin
        mac_ifm_valid <= 1'b1;
        mac_ifm       <= {ifm_in_data, mask_q, inter_end, accum_end};
      end else if (mac_ifm_ready) begin
        mac_ifm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_feed_sequencer.sv
// Directed bench for mac_feed_sequencer: table of pass configurations with
// hand-computed beat/flag counts, plus zero-config, restart and reset-abort cases.
module tb_mac_feed_sequencer;

  localparam int ELEM_W = 8;
  localparam int CNT_W  = 16;
  localparam int DW     = 64 * ELEM_W;
  localparam int CW     = DW + 66;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [CNT_W-1:0]  cfg_wfm_lines, cfg_inter_len, cfg_accum_len, cfg_group_num;
  logic [63:0]       cfg_lane_mask;
  logic              busy, done, cfg_err;
  logic              wfm_in_valid, wfm_in_ready;
  logic [DW-1:0]     wfm_in_data;
  logic              ifm_in_valid, ifm_in_ready;
  logic [DW-1:0]     ifm_in_data;
  logic              mac_wfm_valid, mac_wfm_ready;
  logic [DW:0]       mac_wfm;
  logic              mac_ifm_valid, mac_ifm_ready;
  logic [DW+65:0]    mac_ifm;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          wl, il, al, gn;
    logic [63:0] mask;
    bit          rnd;
    int          restart_at;
    int          exp_w, exp_i, exp_ie, exp_ae, exp_done;
  } vec_t;

  vec_t tbl[6];

  mac_feed_sequencer #(.ELEM_W(ELEM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_wfm_lines(cfg_wfm_lines), .cfg_inter_len(cfg_inter_len),
    .cfg_accum_len(cfg_accum_len), .cfg_group_num(cfg_group_num),
    .cfg_lane_mask(cfg_lane_mask),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .wfm_in_valid(wfm_in_valid), .wfm_in_ready(wfm_in_ready), .wfm_in_data(wfm_in_data),
    .ifm_in_valid(ifm_in_valid), .ifm_in_ready(ifm_in_ready), .ifm_in_data(ifm_in_data),
    .mac_wfm_valid(mac_wfm_valid), .mac_wfm_ready(mac_wfm_ready), .mac_wfm(mac_wfm),
    .mac_ifm_valid(mac_ifm_valid), .mac_ifm_ready(mac_ifm_ready), .mac_ifm(mac_ifm)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk_data(input int seed, input int idx);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = {8'(seed), 8'(idx), 8'(k), 8'hA5};
    return d;
  endfunction

  task automatic check_output(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check_output({name, "_flags"}, CW'({busy, done, cfg_err, wfm_in_ready, ifm_in_ready,
                                        mac_wfm_valid, mac_ifm_valid}), '0);
    check_output({name, "_wfm"}, CW'(mac_wfm), '0);
    check_output({name, "_ifm"}, mac_ifm, '0);
  endtask

  // One pass: start, then per-cycle producer/consumer with sampling 1 ns before the edge.
  task automatic apply_stimulus(input vec_t v, input int abort_at);
    int total = v.il * v.al * v.gn;
    int wsent = 0, wrecv = 0, isent = 0, irecv = 0, ie = 0, ae = 0, s = 0, last_acc = -10;
    bit restarted = 0, wst = 0, ist = 0, fin = 0, completed = 0;
    logic [DW:0]    wheld = '0;
    logic [DW+65:0] iheld = '0;

    @(negedge clk);
    cfg_wfm_lines = CNT_W'(v.wl);
    cfg_inter_len = CNT_W'(v.il);
    cfg_accum_len = CNT_W'(v.al);
    cfg_group_num = CNT_W'(v.gn);
    cfg_lane_mask = v.mask;
    cfg_start     = 1'b1;
    wfm_in_valid  = 1'b0;
    ifm_in_valid  = 1'b0;
    @(negedge clk);
    cfg_wfm_lines = 16'd7;
    cfg_inter_len = 16'd5;
    cfg_accum_len = 16'd3;
    cfg_group_num = 16'd2;
    cfg_lane_mask = 64'hDEAD_BEEF_0BAD_F00D;
    while (!fin) begin
      s++;
      cfg_start = (v.restart_at >= 0) && !restarted && (irecv == v.restart_at);
      if (cfg_start) restarted = 1;
      wfm_in_valid  = (wsent < v.wl) && (!v.rnd || $urandom_range(0, 2) != 0);
      wfm_in_data   = mk_data(1, wsent);
      ifm_in_valid  = (isent < total) && (!v.rnd || $urandom_range(0, 2) != 0);
      ifm_in_data   = mk_data(2, isent);
      mac_wfm_ready = !v.rnd || $urandom_range(0, 2) != 0;
      mac_ifm_ready = !v.rnd || $urandom_range(0, 2) != 0;
      #4;
      if (s == 1) check_output("start_busy", CW'(busy), CW'(1));
      if (abort_at >= 0 && irecv == abort_at) begin
        rst = 1'b1;
        #1;
        check_quiet("abort");
        @(negedge clk);
        rst = 1'b0;
        wfm_in_valid = 1'b0;
        ifm_in_valid = 1'b0;
        fin = 1;
      end else begin
        if (ifm_in_ready) check_int("ifm_ready_early", wrecv, v.wl);
        if (wst) check_output("wfm_hold", CW'({mac_wfm_valid, mac_wfm}), CW'({1'b1, wheld}));
        if (ist) check_output("ifm_hold", CW'({mac_ifm_valid, mac_ifm}), CW'({1'b1, iheld}));
        wst = mac_wfm_valid && !mac_wfm_ready;
        ist = mac_ifm_valid && !mac_ifm_ready;
        wheld = mac_wfm;
        iheld = mac_ifm;
        if (mac_wfm_valid && mac_wfm_ready) begin
          check_output("wfm_beat", CW'(mac_wfm), CW'({mk_data(1, wrecv), wrecv == v.wl - 1}));
          wrecv++;
        end
        if (mac_ifm_valid && mac_ifm_ready) begin
          check_output("ifm_beat", mac_ifm,
                       {mk_data(2, irecv), v.mask, (irecv + 1) % v.il == 0,
                        (irecv + 1) % (v.il * v.al) == 0});
          ie += int'(mac_ifm[1]);
          ae += int'(mac_ifm[0]);
          irecv++;
          last_acc = s;
        end
        if (wfm_in_valid && wfm_in_ready) wsent++;
        if (ifm_in_valid && ifm_in_ready) isent++;
        if (done) begin
          check_int("done_latency", s, last_acc + 1);
          check_output("busy_at_done", CW'(busy), '0);
          check_int("wfm_count", wrecv, v.exp_w);
          check_int("ifm_count", irecv, v.exp_i);
          check_int("inter_end_count", ie, v.exp_ie);
          check_int("accum_end_count", ae, v.exp_ae);
          if (v.exp_done != 0) check_int("done_cycle", s, v.exp_done);
          fin = 1;
          completed = 1;
        end else if (s > 3000) begin
          checks++;
          errors++;
          $display("[TB] FAIL pass_timeout: got no done after %0d cycles, expected done", s);
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          fin = 1;
        end
      end
      if (!fin) @(negedge clk);
    end
    if (completed) begin
      @(negedge clk);
      wfm_in_valid = 1'b0;
      ifm_in_valid = 1'b0;
      #4;
      check_output("after_done", CW'({done, busy, wfm_in_ready, ifm_in_ready}), '0);
    end
  endtask

  initial begin
    tbl[0] = '{2, 3, 2, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 2, 12, 4, 2, 17};
    tbl[1] = '{2, 3, 2, 2, 64'h0123_4567_89AB_CDEF, 1'b1, -1, 2, 12, 4, 2, 0};
    tbl[2] = '{2, 3, 2, 2, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0,  4, 2, 12, 4, 2, 17};
    tbl[3] = '{1, 1, 1, 1, 64'h0000_0000_0000_00FF, 1'b0, -1, 1, 1, 1, 1, 5};
    tbl[4] = '{3, 2, 3, 1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, -1, 3, 6, 3, 1, 0};
    tbl[5] = '{1, 4, 1, 3, 64'h8000_0000_0000_0001, 1'b0, -1, 1, 12, 3, 3, 16};

    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_wfm_lines = '0;
    cfg_inter_len = '0;
    cfg_accum_len = '0;
    cfg_group_num = '0;
    cfg_lane_mask = '0;
    wfm_in_valid = 1'b0;
    wfm_in_data = '0;
    ifm_in_valid = 1'b0;
    ifm_in_data = '0;
    mac_wfm_ready = 1'b0;
    mac_ifm_ready = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    // Each count zeroed in turn must be rejected with a single cfg_err pulse.
    for (int z = 0; z < 4; z++) begin
      @(negedge clk);
      cfg_wfm_lines = (z == 0) ? 16'd0 : 16'd1;
      cfg_inter_len = (z == 1) ? 16'd0 : 16'd1;
      cfg_accum_len = (z == 2) ? 16'd0 : 16'd1;
      cfg_group_num = (z == 3) ? 16'd0 : 16'd1;
      cfg_start = 1'b1;
      wfm_in_valid = 1'b1;
      ifm_in_valid = 1'b1;
      mac_wfm_ready = 1'b1;
      mac_ifm_ready = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      #4;
      check_output("zero_cfg_err", CW'(cfg_err), CW'(1));
      check_output("zero_busy_ready", CW'({busy, wfm_in_ready, ifm_in_ready}), '0);
      @(negedge clk);
      #4;
      check_output("zero_cfg_err_once", CW'({cfg_err, busy}), '0);
    end
    wfm_in_valid = 1'b0;
    ifm_in_valid = 1'b0;

    apply_stimulus(tbl[0], 5);

    for (int i = 0; i < 6; i++) apply_stimulus(tbl[i], -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_feed_sequencer.md
# mac_feed_sequencer

Sequences one MAC-array pass: first streams the weight lines onto the MAC weight port, then streams input-feature beats onto the MAC IFM port. While streaming, it generates the `inter_end` and `accum_end` segment flags and the per-lane valid mask from latched configuration. It sits between the IFM/WFM line buffers and the MAC array, and one registered output stage decouples each side.

## Interface
- `ELEM_W`, default `MAC_W_ELEMENT` (8): bits per lane element; 64 lanes per beat.
- `CNT_W`, default 16: width of all configuration counts.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_start` in 1: one-cycle pulse; latches all `cfg_*` inputs when the block is IDLE.
- `cfg_wfm_lines` in CNT_W: weight lines per pass, must be ≥1.
- `cfg_inter_len` in CNT_W: IFM beats per inter segment, must be ≥1.
- `cfg_accum_len` in CNT_W: inter segments per accumulation group, must be ≥1.
- `cfg_group_num` in CNT_W: accumulation groups per pass, must be ≥1.
- `cfg_lane_mask` in 64: copied to `data_element_valid` on every IFM beat.
- `busy` out 1: high from the accepted start until `done`.
- `done` out 1: one-cycle pulse when the pass completes.
- `cfg_err` out 1: one-cycle pulse when a start is rejected for a zero count.
- `wfm_in_valid` / `wfm_in_ready` in/out 1: weight buffer handshake.
- `wfm_in_data` in 64*ELEM_W: weight line.
- `ifm_in_valid` / `ifm_in_ready` in/out 1: IFM buffer handshake.
- `ifm_in_data` in 64*ELEM_W: IFM beat.
- `mac_wfm_valid` / `mac_wfm_ready` out/in 1: MAC weight-port handshake.
- `mac_wfm` out 64*ELEM_W+1: `{data, is_last_line}`.
- `mac_ifm_valid` / `mac_ifm_ready` out/in 1: MAC IFM-port handshake.
- `mac_ifm` out 64*ELEM_W+66: `{data, data_element_valid[63:0], inter_end, accum_end}`.

## Operation
- **States:** IDLE, LOAD_W, W_DRAIN, STREAM, S_DRAIN.
- **IDLE**
  - On `cfg_start`, if any count is 0: pulse `cfg_err` the next cycle and stay in IDLE.
  - Otherwise: latch the configuration, clear all counters, set `busy`, go to LOAD_W.
  - `cfg_start` outside IDLE is ignored.
- **LOAD_W**
  - `wfm_in_ready = !mac_wfm_valid || mac_wfm_ready`.
  - Each input transfer loads the output register and increments `wl_cnt`.
  - `is_last_line = (wl_cnt == cfg_wfm_lines-1)`.
  - On the last transfer, go to W_DRAIN.
- **W_DRAIN:** `wfm_in_ready=0`, `ifm_in_ready=0`. When `mac_wfm_valid` falls, go to STREAM. No IFM beat is issued before the last weight line has been accepted by the MAC.
- **STREAM**
  - `ifm_in_ready = !mac_ifm_valid || mac_ifm_ready`.
  - Per input transfer:
    - `inter_end = (beat == inter_len-1)`.
    - `accum_end = inter_end && (seg == accum_len-1)`.
  - Counter wrap rules:
    - `beat` wraps to 0 on `inter_end`.
    - `seg` increments on `inter_end` and wraps to 0 on `accum_end`.
    - `grp` increments on `accum_end`.
  - The transfer with `accum_end` and `grp == group_num-1` is the last one; go to S_DRAIN.
- **S_DRAIN:** no input accepted. When `mac_ifm_valid` falls, pulse `done`, clear `busy`, go to IDLE.
- **Output registers:** load on input transfer. `*_valid` clears on the MAC handshake when no new transfer occurs in the same cycle. A simultaneous drain and refill keeps valid high and presents the new data.
- **Arithmetic:** counters are CNT_W bits and compare against latched values only; the per-pass beat total never overflows a counter.
- **Idle outputs:** outside their active state, `wfm_in_ready` and `ifm_in_ready` are 0.

## Timing
- **Reset values:** every output is 0, state is IDLE, counters are 0, output registers are cleared.
- **Reset mid-pass:** aborts immediately. Valids drop asynchronously and no `done` is issued.
- **Start latency:** `cfg_start` at cycle N gives `busy=1` and LOAD_W at N+1. `wfm_in_ready` can be high from N+1.
- **Data latency:** input to MAC output is 1 cycle. Full throughput is 1 beat/cycle when the MAC is always ready.
- **LOAD_W→STREAM gap:** minimum 2 cycles, from the last weight input to the first possible `ifm_in_ready`.
- **Completion:** `done` asserts the cycle after the last IFM beat is accepted by the MAC; `busy` falls in the same cycle.
- **Backpressure:** held data and flags stay stable while valid is high and ready is low.
- **Minimum config:** all counts = 1 gives 1 weight line with `is_last_line=1`, then 1 IFM beat with `inter_end=accum_end=1`.

## Test plan
- **Basic pass:** `wfm_lines=2`, `inter_len=3`, `accum_len=2`, `group_num=2`, MAC always ready.
  - 2 weight beats, `is_last_line` on the 2nd.
  - 12 IFM beats, `inter_end` on beats 3,6,9,12 and `accum_end` on 6,12.
  - `done` 1 cycle after beat 12.
- **Backpressure:** random `mac_*_ready` and random `*_in_valid` → no beat lost or duplicated, data/flags stable while stalled, same flag positions as the basic pass.
- **Zero config:** `cfg_start` with `cfg_inter_len=0` → `cfg_err` one pulse, `busy` stays 0, no ready asserted.
- **Start while busy:** second `cfg_start` mid-STREAM with different counts → ignored; the pass completes with the original counts.
- **Reset mid-STREAM:** `rst` after beat 5 → all outputs 0 immediately. A subsequent start runs a full clean pass with counters from 0.
- **Minimum config:** all counts = 1, `cfg_lane_mask=64'h00FF` → 1 weight beat with `is_last_line=1`, then 1 IFM beat with both ends set and mask `00FF`, then `done`.
